ex_div: RTL and testbench
=========================

# ex_div

Sequential radix-2 restoring divider attached to the EX stage, executing MIPS DIV/DIVU and producing the HI/LO pair. The EX stage issues an operation with `start`. The block raises `stallreq_for_ex` into the stall controller until the quotient and remainder are ready, so IF/ID/EX are frozen for the duration of the division. The block also accepts a flush (`annul`) that cancels an in-flight division.

## Interface
Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  EX requests a division; held high by EX while stalled.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- opdata1  in  WIDTH  dividend; sampled on acceptance.
- opdata2  in  WIDTH  divisor; sampled on acceptance.
- annul  in  1  cancel current or pending operation (flush).
- result  out  2*WIDTH  {remainder (HI), quotient (LO)}.
- ready  out  1  one-cycle pulse: result valid this cycle.
- stallreq_for_ex  out  1  to stall controller; combinational = start & ~annul & ~ready.

## Operation
- Reset (rst low, async):
  - state=FREE, result=0, ready=0, counter=0, internal operand registers=0.
  - stallreq_for_ex is then start & ~annul.
- State machine with four states:
  - FREE
    - start=1 and annul=0 and opdata2=0 → DIVZERO.
    - start=1 and annul=0 and opdata2≠0:
      - latch |opdata1| and |opdata2| (absolute values only when signed_div=1, else raw);
      - latch the sign flags;
      - clear the partial remainder, counter=0;
      - → BUSY.
    - Otherwise stay in FREE.
  - BUSY: one restoring step per cycle.
    - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
    - If the (WIDTH+1)-bit trial rem − divisor is ≥ 0: rem = difference, quo LSB = 1; else quo LSB = 0.
    - Counter increments each step; after step WIDTH → DONE.
    - annul=1 in any BUSY cycle → FREE next edge; no ready, result unchanged.
  - DIVZERO: → DONE next edge with quotient=0 and remainder=0. annul → FREE.
  - DONE (one cycle only):
    - ready=1.
    - result register is written on entry with the sign correction:
      - quotient negated (two's complement) if signed_div and the operand signs differ;
      - remainder negated if signed_div and the dividend was negative.
    - → FREE unconditionally.
- result holds its last value until the next DONE; ready deasserts after exactly one cycle.
- Operands and signed_div changing while BUSY have no effect.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraparound, no trap).
- EX must consume result in the ready cycle. If start is still high in the following FREE cycle, it is treated as a new operation (this covers back-to-back divides).

## Timing
- With start first high in cycle 0 (FREE), for a nonzero divisor:
  - cycles 1..WIDTH: BUSY;
  - cycle WIDTH+1: DONE, ready=1, result valid;
  - stallreq_for_ex is high in cycles 0..WIDTH (WIDTH+1 cycles) and low in cycle WIDTH+1.
- Divisor zero: DIVZERO in cycle 1, ready in cycle 2; stallreq high in cycles 0..1.
- Back-to-back: ready in cycle N; the next start is accepted in cycle N+1 (FREE).
- annul and start high in the same cycle: annul wins. No acceptance, and stallreq is 0.
- Asynchronous reset mid-BUSY: all outputs reach reset values immediately; the next operation starts from FREE after rst rises.
- Critical path: one WIDTH+1-bit subtract plus mux per cycle.

## Test plan
- DIVU 100 / 7: result = {0x00000002, 0x0000000E}, ready in cycle 33 only; stallreq high in cycles 0–32.
- DIV −7 / 2 (0xFFFFFFF9 / 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: result {0x0, 0x80000000}. DIVU 0xFFFFFFFF / 1: {0x0, 0xFFFFFFFF}.
- Divide by zero, 5 / 0: ready in cycle 2, result = 0, stallreq high in cycles 0–1.
- annul asserted in cycle 10 of a BUSY op: state FREE by cycle 11, no ready pulse, result keeps its previous value. A new DIVU 9 / 3 started in cycle 11 yields {0, 3} in cycle 44.
- rst pulled low in cycle 15 of BUSY:
  - result=0 and ready=0 immediately;
  - after release, DIVU 20 / 6 gives {2, 3} with the full 33-cycle latency.
  - Then a back-to-back second DIVU (start held high) is accepted the cycle after ready.

Source files
------------

// File: rtl/ex_div_if.sv
// EX-stage divider handshake bundle.
// EX drives operands and start/annul; divider returns result and stall.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stallreq_for_ex;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stallreq_for_ex
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stallreq_for_ex
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {HI=remainder, LO=quotient}; stalls EX while busy.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    FREE, BUSY, DIVZERO, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic [2*WIDTH-1:0] res_q;

  logic             accept;
  logic             last;
  logic             zero_dvs;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign accept   = bus.start & ~bus.annul;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign zero_dvs = (bus.opdata2 == '0);

  assign abs1 = (bus.signed_div & bus.opdata1[WIDTH-1])
              ? -bus.opdata1 : bus.opdata1;
  assign abs2 = (bus.signed_div & bus.opdata2[WIDTH-1])
              ? -bus.opdata2 : bus.opdata2;

  // Trial subtract is one bit wider so its MSB is the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0]
                                : trial[WIDTH-1:0];
  assign quo_n   = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign q_fix   = neg_q ? -quo_n : quo_n;
  assign r_fix   = neg_r ? -rem_n : rem_n;

  always_comb begin
    state_n = state;
    unique case (state)
      FREE: begin
        if (accept) state_n = zero_dvs ? DIVZERO : BUSY;
      end
      BUSY: begin
        if (bus.annul)  state_n = FREE;
        else if (last)  state_n = DONE;
      end
      DIVZERO: state_n = bus.annul ? FREE : DONE;
      DONE:    state_n = FREE;
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FREE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else begin
      unique case (state)
        FREE: begin
          if (accept && !zero_dvs) begin
            quo   <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= bus.signed_div &
                     (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            neg_r <= bus.signed_div & bus.opdata1[WIDTH-1];
          end
        end
        BUSY: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CW'(1);
          if (last && !bus.annul) res_q <= {r_fix, q_fix};
        end
        DIVZERO: begin
          if (!bus.annul) res_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result          = res_q;
  assign bus.ready           = (state == DONE);
  assign bus.stallreq_for_ex = bus.start & ~bus.annul & ~bus.ready;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table plus annul/reset sequences.
// Expected quotients and remainders are hand computed.
module tb_ex_div;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_div_if #(.WIDTH(32)) bus();
  ex_div #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an op in the current cycle and follows it to ready.
  task automatic do_div(input logic sd,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp,
                        input int lat,
                        input logic keep,
                        input string name);
    int cyc = 0;
    bit got = 0;
    int bad = 0;
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        got = 1;
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " result"}, bus.result, exp);
        check({name, " stall@ready"},
              64'(bus.stallreq_for_ex), 64'd0);
      end else if (bus.stallreq_for_ex !== 1'b1) begin
        bad++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        bus.opdata1    = $urandom;
        bus.opdata2    = $urandom;
        bus.signed_div = ~sd;
      end
    end
    if (!got) check({name, " timeout"}, 64'(cyc), 64'(lat));
    check({name, " stall cycles"}, 64'(bad), 64'd0);
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    logic [63:0] prev;
    bit          seen;

    vecs[0] = '{1'b0, 32'd100, 32'd7,
                {32'h2, 32'hE}, 33, "divu 100/7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h2,
                {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div -7/2"};
    vecs[2] = '{1'b1, 32'h7, 32'hFFFFFFFE,
                {32'h1, 32'hFFFFFFFD}, 33, "div 7/-2"};
    vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                {32'h0, 32'h80000000}, 33, "div min/-1"};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h1,
                {32'h0, 32'hFFFFFFFF}, 33, "divu max/1"};
    vecs[5] = '{1'b0, 32'd5, 32'd0,
                64'h0, 2, "divu 5/0"};
    vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'd7,
                {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, "div -100/7"};
    vecs[7] = '{1'b0, 32'h80000000, 32'hFFFFFFFF,
                {32'h80000000, 32'h0}, 33, "divu big/max"};
    vecs[8] = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD,
                {32'hFFFFFFFE, 32'h2}, 33, "div -8/-3"};

    rst            = 1'b0;
    bus.start      = 1'b1;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    #3;
    check("reset result", bus.result, 64'h0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset stall", 64'(bus.stallreq_for_ex), 64'd1);
    bus.annul = 1'b1;
    #1;
    check("reset stall annul", 64'(bus.stallreq_for_ex), 64'd0);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].lat, 1'b0, vecs[i].name);
      @(negedge clk);
      check({vecs[i].name, " pulse"}, 64'(bus.ready), 64'd0);
      check({vecs[i].name, " hold"}, bus.result, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Annul in cycle 10 of a busy op, then restart in cycle 11.
    prev           = vecs[8].exp;
    seen           = 0;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) seen = 1;
      @(posedge clk);
      #1;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul stall", 64'(bus.stallreq_for_ex), 64'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    check("annul result hold", bus.result, prev);
    check("annul no ready", 64'(seen), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0,
           "divu 9/3 after annul");
    @(posedge clk);
    #1;

    // Annul and start together in FREE: nothing is accepted.
    bus.start   = 1'b1;
    bus.annul   = 1'b1;
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd5;
    @(negedge clk);
    check("start+annul stall", 64'(bus.stallreq_for_ex), 64'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    seen      = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) seen = 1;
    end
    check("start+annul no ready", 64'(seen), 64'd0);
    check("start+annul hold", bus.result, {32'd0, 32'd3});
    @(posedge clk);
    #1;

    // Asynchronous reset in cycle 15 of a busy op.
    bus.start   = 1'b1;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("mid reset result", bus.result, 64'h0);
    check("mid reset ready", 64'(bus.ready), 64'd0);
    check("mid reset stall", 64'(bus.stallreq_for_ex), 64'd1);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_div(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 33, 1'b1,
           "divu 20/6 after reset");
    do_div(1'b0, 32'd50, 32'd7, {32'd1, 32'd7}, 33, 1'b0,
           "divu 50/7 back-to-back");
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
